// File: rtl/kgp_risc_if.sv
// Observation bundle for kgp_risc: committed PC, fetched word, halt flag and the
// write-back / store activity of the current cycle. No handshake; wr_en qualifies wr_addr/wr_data.
interface kgp_risc_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        halted;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        mem_we;
  logic [31:0] mem_addr;

  modport master (
    output pc, instr, halted, wr_en, wr_addr, wr_data, mem_we, mem_addr
  );

  modport slave (
    input pc, instr, halted, wr_en, wr_addr, wr_data, mem_we, mem_addr
  );
endinterface

// File: rtl/kgp_risc.sv
// KGP-RISC single-cycle load/store core. The program image arrives as a packed parameter
// (word i at bits [32*i +: 32]); words at or beyond IMEM_WORDS read as NOP.
module kgp_risc #(
  parameter int                       IMEM_DEPTH = 256,
  parameter int                       DMEM_DEPTH = 256,
  parameter int                       IMEM_WORDS = 0,
  parameter logic [IMEM_DEPTH*32-1:0] IMEM_INIT  = '0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] out,
  kgp_risc_if.master  dbg
);

  localparam int PC_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  localparam logic [31:0] NOP_WORD = 32'h3400_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_SUBI  = 6'h02;
  localparam logic [5:0] OP_ANDI  = 6'h03;
  localparam logic [5:0] OP_ORI   = 6'h04;
  localparam logic [5:0] OP_XORI  = 6'h05;
  localparam logic [5:0] OP_LD    = 6'h06;
  localparam logic [5:0] OP_ST    = 6'h07;
  localparam logic [5:0] OP_BR    = 6'h08;
  localparam logic [5:0] OP_BMI   = 6'h09;
  localparam logic [5:0] OP_BPL   = 6'h0A;
  localparam logic [5:0] OP_BZ    = 6'h0B;
  localparam logic [5:0] OP_HALT  = 6'h0C;
  localparam logic [5:0] OP_MOVE  = 6'h0E;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_d;
  logic [PC_W-1:0]   pc_inc;
  logic [31:0]       out_q;
  logic [31:0]       rf_q [16];
  logic [31:0]       dmem_q [DMEM_DEPTH];
  logic [31:0]       rom [IMEM_DEPTH];

  logic [31:0]       instr;
  logic [5:0]        op;
  logic [3:0]        rs_a;
  logic [3:0]        rt_a;
  logic [3:0]        rd_a;
  logic [3:0]        funct;
  logic [31:0]       imm;
  logic [31:0]       rs_v;
  logic [31:0]       rt_v;
  logic [DA_W-1:0]   dm_addr;
  logic [31:0]       dm_rdata;

  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [31:0]       wr_data;
  logic              mem_we;
  logic              br_taken;
  logic              halt_now;
  logic              run;
  logic              rf_commit;

  for (genvar g = 0; g < IMEM_DEPTH; g++) begin : g_rom
    if (g < IMEM_WORDS) begin : g_img
      assign rom[g] = IMEM_INIT[g*32 +: 32];
    end else begin : g_nop
      assign rom[g] = NOP_WORD;
    end
  end

  assign instr = rom[pc_q];
  assign op    = instr[31:26];
  assign rs_a  = instr[25:22];
  assign rt_a  = instr[21:18];
  assign rd_a  = instr[17:14];
  assign funct = instr[3:0];
  assign imm   = {{14{instr[17]}}, instr[17:0]};

  assign rs_v = (rs_a == 4'd0) ? 32'd0 : rf_q[rs_a];
  assign rt_v = (rt_a == 4'd0) ? 32'd0 : rf_q[rt_a];

  // Address arithmetic is full 32-bit; truncation gives the modulo-depth wrap.
  assign dm_addr  = DA_W'(rs_v + imm);
  assign dm_rdata = dmem_q[dm_addr];

  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = rt_a;
    wr_data  = rs_v;
    mem_we   = 1'b0;
    br_taken = 1'b0;
    halt_now = 1'b0;
    case (op)
      OP_RTYPE: begin
        wr_addr = rd_a;
        wr_en   = 1'b1;
        case (funct)
          4'd0:    wr_data = rs_v + rt_v;
          4'd1:    wr_data = rs_v - rt_v;
          4'd2:    wr_data = rs_v & rt_v;
          4'd3:    wr_data = rs_v | rt_v;
          4'd4:    wr_data = rs_v ^ rt_v;
          4'd5:    wr_data = ~rs_v;
          4'd6:    wr_data = rs_v << rt_v[4:0];
          4'd7:    wr_data = 32'($signed(rs_v) >>> rt_v[4:0]);
          4'd8:    wr_data = rs_v >> rt_v[4:0];
          default: wr_en   = 1'b0;
        endcase
      end
      OP_ADDI: begin wr_en = 1'b1; wr_data = rs_v + imm; end
      OP_SUBI: begin wr_en = 1'b1; wr_data = rs_v - imm; end
      OP_ANDI: begin wr_en = 1'b1; wr_data = rs_v & imm; end
      OP_ORI:  begin wr_en = 1'b1; wr_data = rs_v | imm; end
      OP_XORI: begin wr_en = 1'b1; wr_data = rs_v ^ imm; end
      OP_LD:   begin wr_en = 1'b1; wr_data = dm_rdata; end
      OP_ST:   mem_we   = 1'b1;
      OP_BR:   br_taken = 1'b1;
      OP_BMI:  br_taken = rs_v[31];
      OP_BPL:  br_taken = !rs_v[31] && (rs_v != 32'd0);
      OP_BZ:   br_taken = (rs_v == 32'd0);
      OP_HALT: halt_now = 1'b1;
      OP_MOVE: wr_en    = 1'b1;
      default: ;
    endcase
  end

  assign pc_inc = pc_q + PC_W'(1);
  assign pc_d   = br_taken ? (pc_inc + PC_W'(imm)) : pc_inc;

  assign run       = (state_q == S_RUN);
  assign rf_commit = run && wr_en && (wr_addr != 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      pc_q    <= '0;
      out_q   <= '0;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= '0;
      end
    end else if (run) begin
      if (halt_now) begin
        state_q <= S_HALT;
      end else begin
        pc_q <= pc_d;
      end
      if (rf_commit) begin
        rf_q[wr_addr] <= wr_data;
        out_q         <= wr_data;
      end
    end
  end

  // Data RAM keeps its contents across reset; only stores while running and out of reset land.
  always_ff @(posedge clk) begin
    if (rst && run && mem_we) begin
      dmem_q[dm_addr] <= rt_v;
    end
  end

  assign out = out_q;

  assign dbg.pc       = 32'(pc_q);
  assign dbg.instr    = instr;
  assign dbg.halted   = (state_q == S_HALT);
  assign dbg.wr_en    = rf_commit;
  assign dbg.wr_addr  = wr_addr;
  assign dbg.wr_data  = wr_data;
  assign dbg.mem_we   = run && mem_we;
  assign dbg.mem_addr = 32'(dm_addr);

endmodule

// File: tb/tb_kgp_risc.sv
// Bench for kgp_risc: a directed program checked against a per-edge table, and a
// generated program checked against an instruction-level interpreter with random resets.
module tb_kgp_risc;

  localparam int DIR_DEPTH = 32;
  localparam int DIR_WORDS = 17;
  localparam int RND_DEPTH = 32;
  localparam int RND_DMEM  = 4;
  localparam int NROWS     = 25;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        rst_b;
  logic [31:0] out_a;
  logic [31:0] out_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(int rd, int rs, int rt, int fn);
    return {6'h00, 4'(rs), 4'(rt), 4'(rd), 10'd0, 4'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rt, int rs, int imm);
    return {6'(op), 4'(rs), 4'(rt), 18'(imm)};
  endfunction

  function automatic logic [DIR_DEPTH*32-1:0] dir_img();
    logic [DIR_DEPTH*32-1:0] v;
    v = '0;
    v[32*0  +: 32] = enc_i(1, 1, 0, 5);
    v[32*1  +: 32] = enc_i(1, 2, 0, 7);
    v[32*2  +: 32] = enc_r(3, 1, 2, 0);
    v[32*3  +: 32] = enc_i(1, 1, 0, -8);
    v[32*4  +: 32] = enc_i(1, 4, 0, 2);
    v[32*5  +: 32] = enc_r(2, 1, 4, 7);
    v[32*6  +: 32] = enc_r(3, 1, 4, 8);
    v[32*7  +: 32] = enc_i(1, 1, 0, 'h1234);
    v[32*8  +: 32] = enc_i(1, 6, 0, 'h55);
    v[32*9  +: 32] = enc_i(7, 1, 0, 10);
    v[32*10 +: 32] = enc_i(6, 5, 0, 10);
    v[32*11 +: 32] = enc_i(1, 0, 0, 9);
    v[32*12 +: 32] = enc_i(1, 7, 0, 1);
    v[32*13 +: 32] = enc_i(1, 1, 0, 3);
    v[32*14 +: 32] = enc_i(2, 1, 1, 1);
    v[32*15 +: 32] = enc_i(10, 0, 1, -2);
    v[32*16 +: 32] = enc_i(12, 0, 0, 0);
    return v;
  endfunction

  function automatic logic [RND_DEPTH*32-1:0] rnd_img();
    logic [RND_DEPTH*32-1:0] v;
    logic [31:0] s;
    logic [31:0] w;
    int rs, rt, rd, imm, bimm;
    v = '0;
    s = 32'h1bad_5eed;
    for (int i = 0; i < RND_DEPTH; i++) begin
      s = s ^ (s << 13);
      s = s ^ (s >> 17);
      s = s ^ (s << 5);
      rd   = int'(s[11:8]);
      rs   = int'(s[15:12]);
      rt   = int'(s[19:16]);
      imm  = int'({{14{s[31]}}, s[31:14]});
      bimm = int'(s[22:20]) - 4;
      if (i < RND_DMEM) begin
        w = enc_i(7, 0, 0, i);
      end else if (i == RND_DEPTH - 1) begin
        w = enc_i(8, 0, 0, 0);
      end else begin
        case (int'(s[3:0]))
          0, 1:    w = enc_r(rd, rs, rt, int'(s[7:4]) % 11);
          2, 3, 4, 5, 6: w = enc_i(int'(s[3:0]) - 1, rt, rs, imm);
          7:       w = enc_i(6, rt, rs, imm);
          8:       w = enc_i(7, rt, rs, imm);
          9:       w = enc_i(9, rt, rs, bimm);
          10:      w = enc_i(10, rt, rs, bimm);
          11:      w = enc_i(11, rt, rs, bimm);
          12:      w = enc_i(14, rt, rs, imm);
          13:      w = enc_i(13, rt, rs, imm);
          14:      w = enc_i(8, rt, rs, bimm);
          default: w = enc_i(15, rt, rs, imm);
        endcase
      end
      v[32*i +: 32] = w;
    end
    return v;
  endfunction

  localparam logic [DIR_DEPTH*32-1:0] DIR_IMG = dir_img();
  localparam logic [RND_DEPTH*32-1:0] RND_IMG = rnd_img();

  kgp_risc_if dbg_a();
  kgp_risc_if dbg_b();

  kgp_risc #(
    .IMEM_DEPTH(DIR_DEPTH),
    .DMEM_DEPTH(256),
    .IMEM_WORDS(DIR_WORDS),
    .IMEM_INIT (DIR_IMG)
  ) u_dir (
    .clk(clk),
    .rst(rst_a),
    .out(out_a),
    .dbg(dbg_a)
  );

  kgp_risc #(
    .IMEM_DEPTH(RND_DEPTH),
    .DMEM_DEPTH(RND_DMEM),
    .IMEM_WORDS(RND_DEPTH),
    .IMEM_INIT (RND_IMG)
  ) u_rnd (
    .clk(clk),
    .rst(rst_b),
    .out(out_b),
    .dbg(dbg_b)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Directed vectors: row r is the state after the r-th rising edge with rst_in applied.
  typedef struct {
    logic        rst_in;
    logic [31:0] exp_out;
    int          exp_pc;
    logic        exp_halt;
  } vec_t;

  vec_t tab [NROWS];

  task automatic apply_row(int r);
    @(negedge clk);
    rst_a = tab[r].rst_in;
    @(posedge clk);
    #1;
    chk($sformatf("dir_out[%0d]", r), out_a, tab[r].exp_out);
    chk($sformatf("dir_pc[%0d]", r), dbg_a.pc, 32'(tab[r].exp_pc));
    chk($sformatf("dir_halt[%0d]", r), {31'd0, dbg_a.halted}, {31'd0, tab[r].exp_halt});
  endtask

  // Instruction-level reference for the generated program.
  logic [31:0] m_r [16];
  logic [31:0] m_mem [RND_DMEM];
  logic [31:0] m_out;
  int          m_pc;
  bit          m_halt;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
    m_out  = 32'd0;
    m_pc   = 0;
    m_halt = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] w, a, b, immv, val, ea;
    logic [5:0]  op;
    int dst, nxt, tgt;
    bit wr;
    if (m_halt) return;
    w    = RND_IMG[m_pc*32 +: 32];
    op   = w[31:26];
    a    = m_r[w[25:22]];
    b    = m_r[w[21:18]];
    immv = 32'($signed(w[17:0]));
    ea   = a + immv;
    nxt  = (m_pc + 1) % RND_DEPTH;
    tgt  = (m_pc + 1 + int'($signed(immv))) % RND_DEPTH;
    if (tgt < 0) tgt += RND_DEPTH;
    dst  = int'(w[21:18]);
    wr   = 1'b0;
    val  = 32'd0;
    case (op)
      6'h00: begin
        dst = int'(w[17:14]);
        wr  = 1'b1;
        case (w[3:0])
          4'd0:    val = a + b;
          4'd1:    val = a - b;
          4'd2:    val = a & b;
          4'd3:    val = a | b;
          4'd4:    val = a ^ b;
          4'd5:    val = ~a;
          4'd6:    val = a << b[4:0];
          4'd7:    val = 32'($signed(a) >>> b[4:0]);
          4'd8:    val = a >> b[4:0];
          default: wr  = 1'b0;
        endcase
      end
      6'h01: begin wr = 1'b1; val = a + immv; end
      6'h02: begin wr = 1'b1; val = a - immv; end
      6'h03: begin wr = 1'b1; val = a & immv; end
      6'h04: begin wr = 1'b1; val = a | immv; end
      6'h05: begin wr = 1'b1; val = a ^ immv; end
      6'h06: begin wr = 1'b1; val = m_mem[ea % 32'(RND_DMEM)]; end
      6'h07: m_mem[ea % 32'(RND_DMEM)] = b;
      6'h08: nxt = tgt;
      6'h09: if ($signed(a) < 0) nxt = tgt;
      6'h0A: if ($signed(a) > 0) nxt = tgt;
      6'h0B: if (a == 32'd0) nxt = tgt;
      6'h0C: begin m_halt = 1'b1; nxt = m_pc; end
      6'h0E: begin wr = 1'b1; val = a; end
      default: ;
    endcase
    if (wr && dst != 0) begin
      m_r[dst] = val;
      m_out    = val;
    end
    m_pc = nxt;
  endtask

  initial begin
    int k;
    rst_a = 1'b0;
    rst_b = 1'b0;

    tab[0]  = '{1'b0, 32'h0000_0000, 0,  1'b0};
    tab[1]  = '{1'b1, 32'h0000_0005, 1,  1'b0};
    tab[2]  = '{1'b1, 32'h0000_0007, 2,  1'b0};
    tab[3]  = '{1'b1, 32'h0000_000C, 3,  1'b0};
    tab[4]  = '{1'b1, 32'hFFFF_FFF8, 4,  1'b0};
    tab[5]  = '{1'b1, 32'h0000_0002, 5,  1'b0};
    tab[6]  = '{1'b1, 32'hFFFF_FFFE, 6,  1'b0};
    tab[7]  = '{1'b1, 32'h3FFF_FFFE, 7,  1'b0};
    tab[8]  = '{1'b1, 32'h0000_1234, 8,  1'b0};
    tab[9]  = '{1'b1, 32'h0000_0055, 9,  1'b0};
    tab[10] = '{1'b1, 32'h0000_0055, 10, 1'b0};
    tab[11] = '{1'b1, 32'h0000_1234, 11, 1'b0};
    tab[12] = '{1'b1, 32'h0000_1234, 12, 1'b0};
    tab[13] = '{1'b1, 32'h0000_0001, 13, 1'b0};
    tab[14] = '{1'b1, 32'h0000_0003, 14, 1'b0};
    tab[15] = '{1'b1, 32'h0000_0002, 15, 1'b0};
    tab[16] = '{1'b1, 32'h0000_0002, 14, 1'b0};
    tab[17] = '{1'b1, 32'h0000_0001, 15, 1'b0};
    tab[18] = '{1'b1, 32'h0000_0001, 14, 1'b0};
    tab[19] = '{1'b1, 32'h0000_0000, 15, 1'b0};
    tab[20] = '{1'b1, 32'h0000_0000, 16, 1'b0};
    tab[21] = '{1'b1, 32'h0000_0000, 16, 1'b1};
    tab[22] = '{1'b1, 32'h0000_0000, 16, 1'b1};
    tab[23] = '{1'b1, 32'h0000_0000, 16, 1'b1};
    tab[24] = '{1'b1, 32'h0000_0000, 16, 1'b1};

    repeat (2) @(negedge clk);
    for (int r = 0; r < NROWS; r++) apply_row(r);

    // Restart from a halted core, then reset between edges part way through.
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    chk("halt_reset_out", out_a, 32'd0);
    chk("halt_reset_halt", {31'd0, dbg_a.halted}, 32'd0);
    k = $urandom_range(3, 12);
    for (int r = 1; r <= k; r++) apply_row(r);
    #2;
    rst_a = 1'b0;
    #1;
    chk("mid_reset_out", out_a, 32'd0);
    chk("mid_reset_pc", dbg_a.pc, 32'd0);
    for (int r = 1; r < NROWS; r++) apply_row(r);

    // Generated program against the interpreter, with random asynchronous resets.
    model_reset();
    for (int i = 0; i < RND_DMEM; i++) m_mem[i] = 32'd0;
    @(negedge clk);
    rst_b = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rnd_out[%0d]", c), out_b, m_out);
      chk($sformatf("rnd_pc[%0d]", c), dbg_b.pc, 32'(m_pc));
      if ($urandom_range(0, 39) == 0) begin
        #2;
        rst_b = 1'b0;
        model_reset();
        #1;
        chk($sformatf("rnd_rst_out[%0d]", c), out_b, 32'd0);
        chk($sformatf("rnd_rst_pc[%0d]", c), dbg_b.pc, 32'd0);
        repeat ($urandom_range(1, 2)) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
